// File: rtl/md_iter_unit.sv
// Iterative radix-2 multiply / restoring divide on unsigned magnitudes; DATA_WIDTH+1 cycles start->valid_o.
// Optional MD_EARLY_OUT_EN: zero-operand mul or divide-by-zero jumps straight to DONE (valid_o one cycle after start).
// Backpressure: start_i only accepted in IDLE/DONE; pipeline stalls on busy_o.
module md_iter_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    start_i,
    input  logic                    kill_i,
    input  logic [3:0]              md_op_i,
    input  logic [DATA_WIDTH-1:0]   rs1_i,
    input  logic [DATA_WIDTH-1:0]   rs2_i,
    output logic [2*DATA_WIDTH-1:0] P_QR_o,
    output logic [1:0]              signs_o,
    output logic [3:0]              md_op_o,
    output logic                    busy_o,
    output logic                    valid_o
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);
    localparam logic [W-1:0]  ONE      = W'(1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_hi;
    logic [W-1:0]   r_lo;
    logic [W-1:0]   r_opnd;
    logic [3:0]     r_op_work;
    logic [1:0]     r_signs_work;

    logic           w_accept;
    logic           w_early;
    logic           w_is_div;
    logic           w_dz;
    logic           w_sa;
    logic           w_sb;
    logic           w_neg1;
    logic           w_neg2;
    logic [W-1:0]   w_mag1;
    logic [W-1:0]   w_mag2;
    logic [1:0]     w_signs;
    logic [W:0]     w_sum;
    logic [W:0]     w_rs;
    logic           w_ge;
    logic [W-1:0]   w_diff;
    logic [W-1:0]   w_hi_nxt;
    logic [W-1:0]   w_lo_nxt;

    assign w_accept = start_i && !kill_i && (r_state == S_IDLE || r_state == S_DONE);
    assign busy_o   = (r_state == S_CALC);
    assign valid_o  = (r_state == S_DONE);

    // Divide-by-zero is run as unsigned so the natural iteration yields {all-ones, raw rs1}.
    always_comb begin
        w_is_div = md_op_i[2];
        w_dz     = w_is_div && (rs2_i == '0);
        if (w_is_div) begin
            w_sa = ~md_op_i[0];
            w_sb = ~md_op_i[0];
        end else begin
            w_sa = (md_op_i[1:0] != 2'b11);
            w_sb = ~md_op_i[1];
        end
        w_neg1  = w_sa && !w_dz && rs1_i[W-1];
        w_neg2  = w_sb && !w_dz && rs2_i[W-1];
        w_mag1  = w_neg1 ? (~rs1_i + ONE) : rs1_i;
        w_mag2  = w_neg2 ? (~rs2_i + ONE) : rs2_i;
        w_signs = w_is_div ? {w_neg2, w_neg1} : {w_neg1, w_neg2};
    end

`ifdef MD_EARLY_OUT_EN
    assign w_early = w_is_div ? w_dz : ((rs1_i == '0) || (rs2_i == '0));
`else
    assign w_early = 1'b0;
`endif

    // One iteration step: hi/lo hold product halves for mul, remainder/quotient for div.
    always_comb begin
        w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(W+1){1'b0}});
        w_rs   = {r_hi, r_lo[W-1]};
        w_ge   = (w_rs >= {1'b0, r_opnd});
        w_diff = w_rs[W-1:0] - r_opnd;
        if (r_op_work[2]) begin
            w_hi_nxt = w_ge ? w_diff : w_rs[W-1:0];
            w_lo_nxt = {r_lo[W-2:0], w_ge};
        end else begin
            w_hi_nxt = w_sum[W:1];
            w_lo_nxt = {w_sum[0], r_lo[W-1:1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = w_early ? S_DONE : S_CALC;
            S_CALC: if (r_cnt == CNT_LAST) w_state_nxt = S_DONE;
            S_DONE: begin
                if (w_accept) w_state_nxt = w_early ? S_DONE : S_CALC;
                else          w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (kill_i) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_cnt        <= '0;
            r_hi         <= '0;
            r_lo         <= '0;
            r_opnd       <= '0;
            r_op_work    <= '0;
            r_signs_work <= '0;
            P_QR_o       <= '0;
            signs_o      <= '0;
            md_op_o      <= '0;
        end else if (w_accept) begin
            r_cnt        <= CNT_INIT;
            r_op_work    <= md_op_i;
            r_signs_work <= w_signs;
            r_hi         <= '0;
            r_lo         <= w_is_div ? w_mag1 : w_mag2;
            r_opnd       <= w_is_div ? w_mag2 : w_mag1;
            if (w_early) begin
                P_QR_o  <= w_is_div ? {{W{1'b1}}, rs1_i} : '0;
                signs_o <= 2'b00;
                md_op_o <= md_op_i;
            end
        end else if (r_state == S_CALC && !kill_i) begin
            r_cnt <= r_cnt - CNT_LAST;
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            if (r_cnt == CNT_LAST) begin
                P_QR_o  <= r_op_work[2] ? {w_lo_nxt, w_hi_nxt} : {w_hi_nxt, w_lo_nxt};
                signs_o <= r_signs_work;
                md_op_o <= r_op_work;
            end
        end
    end

endmodule

// File: tb/tb_md_iter_unit.sv
// Directed + random bench for md_iter_unit (DATA_WIDTH=32, default build) against an arithmetic reference model.
module tb_md_iter_unit;
    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        start_i;
    logic        kill_i;
    logic [3:0]  md_op_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic [63:0] P_QR_o;
    logic [1:0]  signs_o;
    logic [3:0]  md_op_o;
    logic        busy_o;
    logic        valid_o;

    int n_checks = 0;
    int n_fail   = 0;

    md_iter_unit #(.DATA_WIDTH(32)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .start_i (start_i),
        .kill_i  (kill_i),
        .md_op_i (md_op_i),
        .rs1_i   (rs1_i),
        .rs2_i   (rs2_i),
        .P_QR_o  (P_QR_o),
        .signs_o (signs_o),
        .md_op_o (md_op_o),
        .busy_o  (busy_o),
        .valid_o (valid_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {signs, P_QR} computed straight from the arithmetic meaning of each op.
    function automatic logic [65:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic        sa, sb, n1, n2;
        logic [31:0] m1, m2;
        logic [63:0] prod;
        if (op[2]) begin
            sa = ~op[0];
            sb = ~op[0];
        end else begin
            sa = (op[1:0] != 2'b11);
            sb = (op[1:0] == 2'b00) || (op[1:0] == 2'b01);
        end
        if (op[2] && b == 32'd0) return {2'b00, 32'hFFFF_FFFF, a};
        n1 = sa && ($signed(a) < 0);
        n2 = sb && ($signed(b) < 0);
        m1 = n1 ? 32'(0 - a) : a;
        m2 = n2 ? 32'(0 - b) : b;
        if (op[2]) return {n2, n1, m1 / m2, m1 % m2};
        prod = 64'(m1) * 64'(m2);
        return {n1, n2, prod};
    endfunction

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start_i = 1'b1;
        md_op_i = op;
        rs1_i   = a;
        rs2_i   = b;
    endtask

    // Called at the negedge where start_i is driven; returns at the negedge of the valid cycle.
    task automatic wait_result(input string tag, input logic [63:0] exp_pqr, input logic [1:0] exp_signs,
                               input logic [3:0] exp_op, input logic [63:0] prev_pqr, input bit glitch);
        int cyc;
        int nbusy;
        @(negedge clk_i);
        start_i = 1'b0;
        cyc     = 1;
        nbusy   = 0;
        check({tag, "_hold"}, P_QR_o, prev_pqr);
        while (!valid_o && cyc < 100) begin
            if (busy_o) nbusy++;
            if (cyc == 5) begin
                rs1_i   = $urandom;
                rs2_i   = $urandom;
                md_op_i = 4'($urandom);
                if (glitch) start_i = 1'b1;
            end
            if (cyc == 6) start_i = 1'b0;
            @(negedge clk_i);
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'd33);
        check({tag, "_busycyc"}, 64'(nbusy), 64'd32);
        check({tag, "_busy_at_valid"}, 64'(busy_o), 64'd0);
        check({tag, "_pqr"}, P_QR_o, exp_pqr);
        check({tag, "_signs"}, 64'(signs_o), 64'(exp_signs));
        check({tag, "_mdop"}, 64'(md_op_o), 64'(exp_op));
    endtask

    task automatic after_valid(input string tag, input logic [63:0] exp_pqr);
        @(negedge clk_i);
        check({tag, "_valid_pulse"}, 64'(valid_o), 64'd0);
        check({tag, "_held"}, P_QR_o, exp_pqr);
    endtask

    initial begin
        logic [63:0] prev;
        logic [65:0] m;
        logic [3:0]  op;
        logic [31:0] a, b;
        int          nvalid;

        reset_i = 1'b1;
        start_i = 1'b0;
        kill_i  = 1'b0;
        md_op_i = 4'd0;
        rs1_i   = 32'd0;
        rs2_i   = 32'd0;
        repeat (3) @(negedge clk_i);
        check("rst_pqr", P_QR_o, 64'd0);
        check("rst_signs", 64'(signs_o), 64'd0);
        check("rst_mdop", 64'(md_op_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_valid", 64'(valid_o), 64'd0);
        reset_i = 1'b0;
        prev = 64'd0;

        // MUL 7 * -3
        @(negedge clk_i);
        issue(4'b0000, 32'd7, 32'hFFFF_FFFD);
        wait_result("mul", 64'h0000_0000_0000_0015, 2'b01, 4'b0000, prev, 1'b0);
        after_valid("mul", 64'h15);
        prev = 64'h15;

        // MULHU max * max, with an ignored start pulse mid-operation
        @(negedge clk_i);
        issue(4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("mulhu", 64'hFFFF_FFFE_0000_0001, 2'b00, 4'b0011, prev, 1'b1);
        after_valid("mulhu", 64'hFFFF_FFFE_0000_0001);
        prev = 64'hFFFF_FFFE_0000_0001;

        // DIV -7 / 2
        @(negedge clk_i);
        issue(4'b0100, 32'hFFFF_FFF9, 32'd2);
        wait_result("div", {32'd3, 32'd1}, 2'b01, 4'b0100, prev, 1'b0);
        prev = {32'd3, 32'd1};

        // DIVU by zero
        @(negedge clk_i);
        issue(4'b0101, 32'h1234_5678, 32'd0);
        wait_result("divu0", {32'hFFFF_FFFF, 32'h1234_5678}, 2'b00, 4'b0101, prev, 1'b0);
        prev = {32'hFFFF_FFFF, 32'h1234_5678};

        // Signed overflow, then back-to-back issue in the DONE cycle
        @(negedge clk_i);
        issue(4'b0100, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_result("divovf", {32'h8000_0000, 32'd0}, 2'b11, 4'b0100, prev, 1'b0);
        prev = {32'h8000_0000, 32'd0};
        issue(4'b1010, 32'hFFFF_FFFE, 32'd3);
        wait_result("b2b_mulhsu", 64'd6, 2'b10, 4'b1010, prev, 1'b0);
        after_valid("b2b_mulhsu", 64'd6);
        prev = 64'd6;

        // Kill mid-operation
        @(negedge clk_i);
        issue(4'b0000, 32'd5, 32'd9);
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        check("kill_busy_c10", 64'(busy_o), 64'd1);
        kill_i = 1'b1;
        @(negedge clk_i);
        kill_i = 1'b0;
        check("kill_busy_c11", 64'(busy_o), 64'd0);
        check("kill_valid_c11", 64'(valid_o), 64'd0);
        check("kill_pqr_c11", P_QR_o, prev);
        nvalid = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (valid_o) nvalid++;
        end
        check("kill_no_valid", 64'(nvalid), 64'd0);
        check("kill_pqr_late", P_QR_o, prev);

        // Kill and start together: start dropped
        issue(4'b0001, 32'd3, 32'd4);
        kill_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        kill_i  = 1'b0;
        check("killstart_busy", 64'(busy_o), 64'd0);

        // Reset mid-operation
        @(negedge clk_i);
        issue(4'b0000, 32'd5, 32'd9);
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        check("midrst_pqr", P_QR_o, 64'd0);
        check("midrst_signs", 64'(signs_o), 64'd0);
        check("midrst_mdop", 64'(md_op_o), 64'd0);
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_valid", 64'(valid_o), 64'd0);
        prev = 64'd0;

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom);
            case ($urandom_range(0, 5))
                0:       a = 32'h8000_0000;
                1:       a = 32'hFFFF_FFFF;
                2:       a = 32'd0;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0:       b = 32'h8000_0000;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'd0;
                3:       b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            m = model(op, a, b);
            @(negedge clk_i);
            issue(op, a, b);
            wait_result("rand", m[63:0], m[65:64], op, prev, i[0]);
            prev = m[63:0];
        end
        after_valid("rand_last", prev);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/md_iter_unit.md
Name: md_iter_unit

Overview:
Iterative radix-2 multiply/divide datapath feeding the M-extension result formatter. Accepts raw rs1/rs2 operands and the 4-bit M-op code, latches operand signs, and iterates on unsigned magnitudes. It produces the raw 2*DATA_WIDTH product, or the quotient and remainder, plus the sign pair that the formatter uses for sign fix-up and result selection. It sits in EX, and the pipeline stalls on busy_o.

Parameters:
DATA_WIDTH, 32, operand width (32 or 64); iteration count equals DATA_WIDTH.

Ports:
clk_i  input  1  core clock
reset_i  input  1  synchronous, active-high reset
start_i  input  1  launch an operation; sampled only when the unit is ready
kill_i  input  1  abort the in-flight operation (pipeline flush)
md_op_i  input  4  [2]=div/rem, [1:0]=funct3 low bits, [3]=word-op (RV64 only, passed through)
rs1_i  input  DATA_WIDTH  multiplicand / dividend
rs2_i  input  DATA_WIDTH  multiplier / divisor
P_QR_o  output  2*DATA_WIDTH  mul: full unsigned magnitude product; div: {Q, R} (Q in upper half)
signs_o  output  2  sign pair for the formatter (encoding below)
md_op_o  output  4  md_op_i latched at start
busy_o  output  1  high while iterating
valid_o  output  1  one-cycle pulse; result outputs valid from this cycle on

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous, active-high, on reset_i.
- Reset values: state=IDLE; P_QR_o=0; signs_o=0; md_op_o=0; busy_o=0; valid_o=0; counter=0.
- FSM states:
  - IDLE: accepts start_i; goes to CALC.
  - CALC: counter decrements from DATA_WIDTH. Goes to DONE when counter reaches 1 and the last step is taken.
  - DONE: valid_o=1 for exactly one cycle. Goes to IDLE, or to CALC if start_i is high.
- Ready condition: start_i is accepted only in IDLE or DONE (back-to-back issue allowed). start_i during CALC is ignored.
- Latency: start_i sampled at edge 0 gives CALC cycles 1..DATA_WIDTH and valid_o in cycle DATA_WIDTH+1 (cycle 33 for DATA_WIDTH=32). busy_o = (state==CALC).
- Operand signedness (sa = rs1 signed, sb = rs2 signed):
  - mul 00 MUL and 01 MULH: sa=sb=1.
  - mul 10 MULHSU: sa=1, sb=0.
  - mul 11 MULHU: sa=sb=0.
  - div 00 DIV and 10 REM: signed.
  - div 01 DIVU and 11 REMU: unsigned.
- Magnitudes: |x| = two's complement of x if signed and MSB=1, else x. The most negative value maps to 2^(W-1) unsigned; no overflow.
- signs_o for mul: {sa & rs1[W-1], sb & rs2[W-1]}.
- signs_o for div: {sb & rs2[W-1], sa & rs1[W-1]}, i.e. bit0 = dividend sign and bit1 = divisor sign.
- Mul iteration (shift-add):
  - {hi, lo} starts as {0, |rs2|}.
  - Each cycle: if lo[0], hi += |rs1| with a W+1-bit carry; then {carry, hi, lo} shifts right by 1.
  - P_QR_o = {hi, lo} at DONE.
- Div iteration (restoring):
  - {rem, quo} starts as {0, |rs1|}.
  - Each cycle: shift left by 1; trial = rem - |rs2|. If no borrow, rem = trial and quo[0] = 1.
  - P_QR_o = {quo, rem}.
- Divide by zero (rs2==0, any div op): P_QR_o = {all-ones, rs1_i raw}, signs_o = 2'b00. Full latency still applies unless the optional feature is enabled. The formatter then yields Q=-1 and R=rs1.
- Signed overflow (-2^(W-1) / -1): needs no special case. The natural result is Q=2^(W-1), R=0, signs=11.
- Output holding: P_QR_o, signs_o and md_op_o update only at DONE entry and hold until the next DONE. The internal working registers are separate.
- kill_i: in any state, kill_i forces IDLE next cycle. valid_o stays 0 and the outputs keep their previous values. kill_i and start_i in the same cycle: kill wins and start is dropped.
- reset_i mid-operation: returns to the reset values next edge. No valid_o is issued.

Optional Feature:
MD_EARLY_OUT_EN:
- Defined: if the mul has either operand equal to 0, or the div has rs2==0, the unit goes IDLE→DONE directly. valid_o is high in cycle 1 after start, with the same result values as the full-latency path (mul zero gives P_QR_o=0, signs_o=00).
- Undefined: every operation takes DATA_WIDTH+1 cycles.

Test Plan:
1. MUL rs1=7, rs2=0xFFFFFFFD (-3), start at cycle 0 -> busy_o high cycles 1-32; valid_o only at cycle 33; P_QR_o=0x0000000000000015; signs_o=2'b01.
2. MULHU rs1=rs2=0xFFFFFFFF -> P_QR_o=0xFFFFFFFE00000001, signs_o=00, md_op_o=4'b0011.
3. DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> P_QR_o={0x00000003, 0x00000001}, signs_o=2'b01.
4. DIVU rs1=0x12345678, rs2=0 -> P_QR_o={0xFFFFFFFF, 0x12345678}, signs_o=00. Valid at cycle 33, or cycle 1 with MD_EARLY_OUT_EN.
5. DIV rs1=0x80000000, rs2=0xFFFFFFFF -> P_QR_o={0x80000000, 0}, signs_o=11. Then issue start in the DONE cycle -> second op accepted with no idle gap.
6. Start MUL, assert kill_i at cycle 10 -> IDLE at cycle 11, no valid_o, P_QR_o unchanged. Repeat with reset_i at cycle 10 -> all outputs 0 at cycle 11.
